aes_controller: RTL and testbench

Sequencing FSM for the byte-serial AES-128 datapath. It accepts a start command and an encrypt/decrypt mode, and drives all datapath control lines through the rounds: key load, round-key generation and save, reverse-order round-key recall, and output drain. It paces every phase from the datapath's 0..15 inner state counter and presents a simple start/busy/done handshake to the user.

---
 rtl/aes_controller.sv | 147 ++++++++++++++
 tb/tb_aes_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_controller.sv
// Sequencing FSM for a byte-serial AES-128 datapath: paces key load, key
// expansion, the rounds and the output drain from the datapath byte counter.
module aes_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       decrypt_mode,
  input  logic [3:0] inner_state_counter,
  output logic       key_rd,
  output logic       data_rd,
  output logic       out_valid,
  output logic       busy,
  output logic       done,
  output logic       rst_synch,
  output logic       en_generator,
  output logic       encrypt,
  output logic       first_round,
  output logic [3:0] round_counter,
  output logic       read_key_in,
  output logic       load_round_key,
  output logic       save_round_key,
  output logic [7:0] addr_round_key_mem
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ROUND, KLOAD, KEXP, DLOAD, DROUND, OUT
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  state_t     state, state_next;
  logic [3:0] rnd, rnd_next;
  logic       encrypt_next;
  logic       last_byte;

  assign last_byte          = (inner_state_counter == 4'd15);
  assign busy               = (state != IDLE);
  assign addr_round_key_mem = {rnd, 4'b0000} + {4'b0000, inner_state_counter};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rnd     <= 4'd0;
      encrypt <= 1'b1;
    end else begin
      state   <= state_next;
      rnd     <= rnd_next;
      encrypt <= encrypt_next;
    end
  end

  // Every phase is 16 bytes long; transitions happen on byte 15 only.
  always_comb begin
    state_next     = state;
    rnd_next       = rnd;
    encrypt_next   = encrypt;
    key_rd         = 1'b0;
    data_rd        = 1'b0;
    out_valid      = 1'b0;
    done           = 1'b0;
    rst_synch      = 1'b0;
    en_generator   = 1'b0;
    first_round    = 1'b0;
    round_counter  = 4'd0;
    read_key_in    = 1'b0;
    load_round_key = 1'b0;
    save_round_key = 1'b0;

    case (state)
      IDLE: begin
        rst_synch = 1'b1;
        if (start) begin
          encrypt_next = ~decrypt_mode;
          rnd_next     = 4'd0;
          state_next   = decrypt_mode ? KLOAD : LOAD;
        end
      end
      LOAD: begin
        key_rd         = 1'b1;
        data_rd        = 1'b1;
        read_key_in    = 1'b1;
        first_round    = 1'b1;
        save_round_key = 1'b1;
        if (last_byte) begin
          state_next = ROUND;
          rnd_next   = 4'd1;
        end
      end
      ROUND: begin
        en_generator   = 1'b1;
        save_round_key = 1'b1;
        round_counter  = rnd;
        if (last_byte) begin
          if (rnd == LAST_ROUND) state_next = OUT;
          else                   rnd_next   = rnd + 4'd1;
        end
      end
      KLOAD: begin
        key_rd         = 1'b1;
        read_key_in    = 1'b1;
        save_round_key = 1'b1;
        if (last_byte) begin
          state_next = KEXP;
          rnd_next   = 4'd1;
        end
      end
      KEXP: begin
        en_generator   = 1'b1;
        save_round_key = 1'b1;
        round_counter  = rnd;
        if (last_byte) begin
          if (rnd == LAST_ROUND) state_next = DLOAD;
          else                   rnd_next   = rnd + 4'd1;
        end
      end
      DLOAD: begin
        data_rd        = 1'b1;
        first_round    = 1'b1;
        load_round_key = 1'b1;
        round_counter  = LAST_ROUND;
        if (last_byte) begin
          state_next = DROUND;
          rnd_next   = 4'd9;
        end
      end
      // Decryption recalls round keys from the top of memory downwards.
      DROUND: begin
        load_round_key = 1'b1;
        round_counter  = rnd;
        if (last_byte) begin
          if (rnd == 4'd0) state_next = OUT;
          else             rnd_next   = rnd - 4'd1;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (last_byte) begin
          done       = 1'b1;
          state_next = IDLE;
          rnd_next   = 4'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_controller.sv
// Scoreboard bench for aes_controller: stimulus queues expected operation
// timing, a negedge monitor checks control sequencing against it.
module tb_aes_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       decrypt_mode = 1'b0;
  logic [3:0] inner_state_counter = 4'd0;
  logic       key_rd, data_rd, out_valid, busy, done, rst_synch;
  logic       en_generator, encrypt, first_round, read_key_in;
  logic       load_round_key, save_round_key;
  logic [3:0] round_counter;
  logic [7:0] addr_round_key_mem;

  typedef struct {
    int t0;
    bit enc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  int save_idx = 0, load_idx = 0, gen_idx = 0, ov_cnt = 0, first_ov = 0;
  int key_cnt = 0, data_cnt = 0, fr_cnt = 0, rk_cnt = 0;

  aes_controller dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .decrypt_mode       (decrypt_mode),
    .inner_state_counter(inner_state_counter),
    .key_rd             (key_rd),
    .data_rd            (data_rd),
    .out_valid          (out_valid),
    .busy               (busy),
    .done               (done),
    .rst_synch          (rst_synch),
    .en_generator       (en_generator),
    .encrypt            (encrypt),
    .first_round        (first_round),
    .round_counter      (round_counter),
    .read_key_in        (read_key_in),
    .load_round_key     (load_round_key),
    .save_round_key     (save_round_key),
    .addr_round_key_mem (addr_round_key_mem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the datapath byte counter, cleared by rst_synch.
  always @(posedge clk) begin
    if (rst_synch) inner_state_counter <= 4'd0;
    else           inner_state_counter <= inner_state_counter + 4'd1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic clearTrackers();
    save_idx = 0; load_idx = 0; gen_idx = 0; ov_cnt = 0; first_ov = 0;
    key_cnt = 0; data_cnt = 0; fr_cnt = 0; rk_cnt = 0;
  endtask

  // Monitor: per-byte address/round checks and end-of-operation scoreboard pop.
  always @(negedge clk) begin
    if (!rst) begin
      clearTrackers();
      checkOutput("reset_ctrl", {key_rd, data_rd, out_valid, busy, done, en_generator,
                  first_round, read_key_in, load_round_key, save_round_key}, 0);
      checkOutput("reset_rst_synch", rst_synch, 1);
      checkOutput("reset_encrypt", encrypt, 1);
      checkOutput("reset_round_counter", round_counter, 0);
      checkOutput("reset_addr", addr_round_key_mem, inner_state_counter);
    end else begin
      if (save_round_key) begin
        checkOutput("save_addr", addr_round_key_mem, save_idx);
        save_idx++;
      end
      if (load_round_key) begin
        checkOutput("load_addr", addr_round_key_mem, (10 - load_idx / 16) * 16 + load_idx % 16);
        checkOutput("load_round", round_counter, 10 - load_idx / 16);
        load_idx++;
      end
      if (en_generator) begin
        checkOutput("gen_round", round_counter, 1 + gen_idx / 16);
        gen_idx++;
      end
      if (first_round) begin
        if (exp_q.size() > 0) checkOutput("first_round_rc", round_counter, exp_q[0].enc ? 0 : 10);
        fr_cnt++;
      end
      if (key_rd)      key_cnt++;
      if (data_rd)     data_cnt++;
      if (read_key_in) rk_cnt++;
      if (out_valid) begin
        if (ov_cnt == 0) first_ov = cyc;
        ov_cnt++;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("done_cycle", cyc, e.t0 + (e.enc ? 192 : 368));
          checkOutput("first_out_cycle", first_ov, e.t0 + (e.enc ? 177 : 353));
          checkOutput("out_bytes", ov_cnt, 16);
          checkOutput("done_with_valid", out_valid, 1);
          checkOutput("encrypt_latch", encrypt, e.enc);
          checkOutput("save_count", save_idx, 176);
          checkOutput("load_count", load_idx, e.enc ? 0 : 176);
          checkOutput("gen_count", gen_idx, 160);
          checkOutput("key_rd_count", key_cnt, 16);
          checkOutput("data_rd_count", data_cnt, 16);
          checkOutput("first_round_count", fr_cnt, 16);
          checkOutput("read_key_in_count", rk_cnt, 16);
        end
        clearTrackers();
      end
    end
  end

  // Called at a negedge; start is high for exactly one cycle, labelled t0.
  task automatic applyStimulus(input bit dec, output int t0);
    exp_t e;
    checkOutput("idle_before_start", busy, 0);
    start        = 1'b1;
    decrypt_mode = dec;
    t0           = cyc;
    e.t0         = cyc;
    e.enc        = ~dec;
    exp_q.push_back(e);
    @(negedge clk);
    start        = 1'b0;
    decrypt_mode = 1'b0;
  endtask

  task automatic pulseIgnoredStart(input bit dec);
    start        = 1'b1;
    decrypt_mode = dec;
    @(negedge clk);
    start        = 1'b0;
    decrypt_mode = 1'b0;
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic waitDrain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 800) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Aborts any operation: its expected result is discarded.
  task automatic resetPulse();
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int t0, t1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    $display("[TB] single encrypt");
    applyStimulus(1'b0, t0);
    waitDrain();

    $display("[TB] single decrypt");
    applyStimulus(1'b1, t0);
    waitDrain();

    $display("[TB] start while busy and on done cycle");
    applyStimulus(1'b0, t0);
    waitCycle(t0 + 50);
    pulseIgnoredStart(1'b1);
    waitCycle(t0 + 192);
    pulseIgnoredStart(1'b1);
    waitDrain();
    repeat (20) @(negedge clk);
    checkOutput("ignored_start_idle", busy, 0);

    $display("[TB] back-to-back encrypt then decrypt");
    applyStimulus(1'b0, t0);
    waitCycle(t0 + 193);
    applyStimulus(1'b1, t1);
    checkOutput("b2b_start_cycle", t1, t0 + 193);
    waitDrain();

    $display("[TB] reset during encrypt round");
    applyStimulus(1'b0, t0);
    waitCycle(t0 + 100);
    resetPulse();
    applyStimulus(1'b0, t0);
    waitDrain();

    $display("[TB] reset during key expansion");
    applyStimulus(1'b1, t0);
    waitCycle(t0 + 60);
    resetPulse();
    repeat (5) @(negedge clk);
    checkOutput("post_reset_busy", busy, 0);
    checkOutput("post_reset_encrypt", encrypt, 1);
    applyStimulus(1'b1, t0);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
